stat_sequencer: RTL and testbench

STAT_SEQUENCER -- requirements
Module: stat_sequencer

---
 rtl/stat_pkg.sv | 24 ++
 rtl/stat_bin_reader.sv | 99 +++++++++
 rtl/stat_sequencer.sv | 137 +++++++++++++
 tb/tb_stat_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stat_pkg.sv
// Shared state encoding and default timing constants for the statistics sequencer.
package stat_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_COLLECT = 3'd2,
    S_FLUSH   = 3'd3,
    S_ISSUE   = 3'd4,
    S_WAIT    = 3'd5,
    S_PRESENT = 3'd6,
    S_DONE    = 3'd7
  } stat_state_e;

  localparam int unsigned STAT_FLUSH_CYC_DEF = 6;
  localparam int unsigned STAT_RD_LAT_DEF    = 2;
  localparam int          TMR_W              = 16;

  // Down-counter load value for a wait of cyc cycles ending on terminal count 0.
  function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cyc);
    return (cyc > 0) ? TMR_W'(cyc - 1) : '0;
  endfunction

endpackage

// File: rtl/stat_bin_reader.sv
// Histogram readout: walks every bin, waits the read latency, presents each count.
// Build macro STAT_SKIP_ZERO_EN drops bins whose captured count is zero.
module stat_bin_reader
  import stat_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int RD_LAT = STAT_RD_LAT_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      stat_summary,
  input  logic             out_rdy,
  output logic [DSIZE-1:0] stat_index,
  output logic             stat_get_summary,
  output logic [DSIZE-1:0] out_bin,
  output logic [31:0]      out_cnt,
  output logic             out_vld,
  output logic             last_done
);

  localparam logic [DSIZE-1:0] BIN_MAX = '1;

  stat_state_e      state;
  logic [DSIZE-1:0] bin;
  logic [TMR_W-1:0] lat_tmr;
  logic             lat_tc;
  logic             last_bin;
  logic             skip;
  logic             hs;

  assign lat_tc   = (lat_tmr == '0);
  assign last_bin = (bin == BIN_MAX);
  assign hs       = (state == S_PRESENT) && out_rdy;

`ifdef STAT_SKIP_ZERO_EN
  assign skip = (stat_summary == 32'd0);
`else
  assign skip = 1'b0;
`endif

  assign stat_index       = bin;
  assign stat_get_summary = (state == S_ISSUE) || (state == S_WAIT);
  assign out_vld          = (state == S_PRESENT);
  assign last_done        = !abort && last_bin &&
                            (hs || ((state == S_WAIT) && lat_tc && skip));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bin     <= '0;
      lat_tmr <= '0;
      out_bin <= '0;
      out_cnt <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bin   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_tmr <= tmr_load(RD_LAT);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!lat_tc) begin
            lat_tmr <= lat_tmr - TMR_W'(1);
          end else if (!skip) begin
            out_cnt <= stat_summary;
            out_bin <= bin;
            state   <= S_PRESENT;
          end else if (last_bin) begin
            state <= S_IDLE;
          end else begin
            bin   <= bin + DSIZE'(1);
            state <= S_ISSUE;
          end
        end
        S_PRESENT: begin
          if (out_rdy) begin
            if (last_bin) begin
              state <= S_IDLE;
            end else begin
              bin   <= bin + DSIZE'(1);
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stat_sequencer.sv
// Statistics run sequencer: clear, collect cfg_len samples, flush, then read out every bin.
// Build macro STAT_SKIP_ZERO_EN suppresses zero-count bins in the readout.
//
// state     | meaning
// S_IDLE    | waiting for go
// S_START   | one-cycle histogram clear, sample counter reset
// S_COLLECT | forwarding samples until cfg_len accepted
// S_FLUSH   | FLUSH_CYC cycle drain before readout
// S_ISSUE   | readout in progress, ISSUE/WAIT/PRESENT owned by stat_bin_reader
// S_DONE    | one-cycle done pulse
module stat_sequencer
  import stat_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int RD_LAT    = STAT_RD_LAT_DEF,
  parameter int FLUSH_CYC = STAT_FLUSH_CYC_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [31:0]      cfg_len,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             stat_start,
  output logic             stat_finish,
  output logic [DSIZE-1:0] stat_data,
  output logic             stat_vld,
  output logic [DSIZE-1:0] stat_index,
  output logic             stat_get_summary,
  input  logic [31:0]      stat_summary,
  output logic [DSIZE-1:0] out_bin,
  output logic [31:0]      out_cnt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done
);

  stat_state_e      state;
  logic [31:0]      len_q;
  logic [31:0]      smp_cnt;
  logic [31:0]      smp_nxt;
  logic [TMR_W-1:0] fl_tmr;
  logic             fl_tc;
  logic             rd_start;
  logic             rd_abort;
  logic             rd_last;

  assign busy       = (state != S_IDLE);
  assign stat_start = (state == S_START);
  assign in_rdy     = (state == S_COLLECT);
  assign done       = (state == S_DONE);
  assign smp_nxt    = smp_cnt + 32'd1;
  assign fl_tc      = (fl_tmr == '0);
  assign rd_abort   = abort && busy;
  assign rd_start   = (state == S_FLUSH) && fl_tc && !abort;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      smp_cnt     <= '0;
      fl_tmr      <= '0;
      stat_data   <= '0;
      stat_vld    <= 1'b0;
      stat_finish <= 1'b0;
    end else begin
      stat_vld    <= 1'b0;
      stat_finish <= 1'b0;
      if (rd_abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              len_q <= cfg_len;
              state <= S_START;
            end
          end
          S_START: begin
            smp_cnt <= '0;
            if (len_q == 32'd0) begin
              stat_finish <= 1'b1;
              fl_tmr      <= tmr_load(FLUSH_CYC);
              state       <= S_FLUSH;
            end else begin
              state <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            if (in_vld) begin
              stat_data <= in_data;
              stat_vld  <= 1'b1;
              smp_cnt   <= smp_nxt;
              // finish lands on the same edge as the last forwarded sample
              if (smp_nxt == len_q) begin
                stat_finish <= 1'b1;
                fl_tmr      <= tmr_load(FLUSH_CYC);
                state       <= S_FLUSH;
              end
            end
          end
          S_FLUSH: begin
            if (fl_tc) state  <= S_ISSUE;
            else       fl_tmr <= fl_tmr - TMR_W'(1);
          end
          S_ISSUE: begin
            if (rd_last) state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  stat_bin_reader #(
    .DSIZE  (DSIZE),
    .RD_LAT (RD_LAT)
  ) u_reader (
    .clock            (clock),
    .rst_n            (rst_n),
    .start            (rd_start),
    .abort            (rd_abort),
    .stat_summary     (stat_summary),
    .out_rdy          (out_rdy),
    .stat_index       (stat_index),
    .stat_get_summary (stat_get_summary),
    .out_bin          (out_bin),
    .out_cnt          (out_cnt),
    .out_vld          (out_vld),
    .last_done        (rd_last)
  );

endmodule

// File: tb/tb_stat_sequencer.sv
// Testbench for stat_sequencer: histogram block emulator plus a counting reference model.
module tb_stat_sequencer;

  localparam int DSIZE     = 8;
  localparam int RD_LAT    = 2;
  localparam int FLUSH_CYC = 6;
  localparam int NBIN      = 1 << DSIZE;
`ifdef STAT_SKIP_ZERO_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst_n;
  logic             go, abort, in_vld, out_rdy;
  logic [31:0]      cfg_len;
  logic [DSIZE-1:0] in_data;
  logic             in_rdy, stat_start, stat_finish, stat_vld, stat_get_summary;
  logic [DSIZE-1:0] stat_data, stat_index, out_bin;
  logic [31:0]      stat_summary, out_cnt;
  logic             out_vld, busy, done;

  always #5 clock = ~clock;

  stat_sequencer #(.DSIZE(DSIZE), .RD_LAT(RD_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clock(clock), .rst_n(rst_n), .go(go), .abort(abort), .cfg_len(cfg_len),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .stat_start(stat_start), .stat_finish(stat_finish),
    .stat_data(stat_data), .stat_vld(stat_vld),
    .stat_index(stat_index), .stat_get_summary(stat_get_summary),
    .stat_summary(stat_summary),
    .out_bin(out_bin), .out_cnt(out_cnt), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy), .done(done)
  );

  // Histogram block the sequencer talks to, with RD_LAT registered read stages.
  int unsigned hist [NBIN];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clock) begin
    if (stat_start) for (int i = 0; i < NBIN; i++) hist[i] <= 0;
    else if (stat_vld) hist[stat_data] <= hist[stat_data] + 1;
    rd_pipe[0] <= hist[stat_index];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign stat_summary = rd_pipe[RD_LAT-1];

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_start, n_vld, n_fin, n_done, fin_lone, fin_cyc, gs_cyc;
  bit gs_seen, acc;
  logic [DSIZE-1:0] rbin [$];
  logic [31:0]      rcnt [$];
  int unsigned      q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_start = 0; n_vld = 0; n_fin = 0; n_done = 0; fin_lone = 0;
    fin_cyc = 0; gs_cyc = 0; gs_seen = 0;
    rbin.delete(); rcnt.delete();
  endtask

  // Observe at the falling edge what the next rising edge will act on.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (rst_n) begin
      if (stat_start) n_start++;
      if (stat_vld) n_vld++;
      if (stat_finish) begin n_fin++; fin_cyc = cyc; if (!stat_vld) fin_lone++; end
      if (stat_get_summary && !gs_seen) begin gs_seen = 1; gs_cyc = cyc; end
      if (out_vld && out_rdy) begin rbin.push_back(out_bin); rcnt.push_back(out_cnt); end
      if (done) n_done++;
    end
    acc = in_vld && in_rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int len, input int unsigned smp [$], input int stall_bin);
    int k = 0;
    int budget = 20000;
    int exp_cnt [NBIN];
    int stall = 0;
    bit stalled = 0;
    bit moved = 0;
    logic [DSIZE-1:0] eb [$];
    logic [31:0]      ec [$];
    int nchk;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    for (int i = 0; i < len; i++) exp_cnt[smp[i]]++;
    for (int b = 0; b < NBIN; b++)
      if (!SKIP0 || exp_cnt[b] != 0) begin eb.push_back(DSIZE'(b)); ec.push_back(exp_cnt[b]); end
    clr_mon();
    cfg_len = len; go = 1; step(); go = 0;
    cfg_len = $urandom;
    while (n_done == 0 && budget > 0) begin
      budget--;
      if (stall_bin >= 0 && !stalled && out_vld && out_bin == DSIZE'(stall_bin)) begin
        stalled = 1; stall = 10;
      end
      in_vld  = ($urandom_range(0, 3) != 0);
      in_data = (k < len) ? DSIZE'(smp[k]) : DSIZE'($urandom);
      go      = ($urandom_range(0, 15) == 0);
      if (stall > 0) begin
        out_rdy = 0;
        step();
        stall--;
        if (!(out_vld && out_bin == DSIZE'(stall_bin) && stat_index == DSIZE'(stall_bin) &&
              out_cnt == 32'(exp_cnt[stall_bin]))) moved = 1;
        if (stall == 0) begin
          chk("stall_bin", out_bin, stall_bin);
          chk("stall_cnt", out_cnt, exp_cnt[stall_bin]);
          chk("stall_index", stat_index, stall_bin);
          chk("stall_stable", moved, 0);
        end
      end else begin
        out_rdy = ($urandom_range(0, 3) != 0);
        step();
      end
      if (acc) k++;
    end
    go = 0; in_vld = 0; out_rdy = 0;
    step(); step();
    chk("done_count", n_done, 1);
    chk("busy_end", busy, 0);
    chk("start_count", n_start, 1);
    chk("vld_count", n_vld, len);
    chk("finish_count", n_fin, 1);
    if (len > 0) chk("finish_with_last_vld", fin_lone, 0);
    chk("flush_wait", gs_cyc - fin_cyc, FLUSH_CYC);
    chk("result_count", rbin.size(), eb.size());
    nchk = (rbin.size() < eb.size()) ? rbin.size() : eb.size();
    for (int i = 0; i < nchk; i++) begin
      chk("result_bin", rbin[i], eb[i]);
      chk("result_cnt", rcnt[i], ec[i]);
    end
  endtask

  initial begin
    int n;
    rst_n = 0; go = 0; abort = 0; cfg_len = 0; in_data = 0; in_vld = 0; out_rdy = 0;
    repeat (3) step();
    chk("reset_outputs", {in_rdy, stat_start, stat_finish, stat_data, stat_vld, stat_index,
        stat_get_summary, out_bin, out_cnt, out_vld, busy, done}, 64'd0);
    rst_n = 1;
    clr_mon();
    step(); step();
    chk("release_busy", busy, 0);
    chk("release_pulses", n_start + n_fin + n_done + n_vld, 0);

    q = {3, 3, 7, 3};
    run(4, q, 5);

    q.delete();
    run(0, q, -1);

    // abort after two accepted samples, with a coincident go
    clr_mon();
    cfg_len = 10; go = 1; step(); go = 0;
    n = 0;
    while (n < 2 && cyc < 60000) begin
      in_vld = 1; in_data = DSIZE'($urandom); step();
      if (acc) n++;
    end
    in_vld = 0; abort = 1; go = 1; step(); abort = 0; go = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in_rdy", in_rdy, 0);
    chk("abort_stat_vld", stat_vld, 0);
    repeat (20) step();
    chk("abort_no_finish", n_fin, 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_vld_count", n_vld, 2);
    chk("abort_idle", busy, 0);

    q = {1, 1, 200};
    run(3, q, -1);

    for (int r = 0; r < 2; r++) begin
      q.delete();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, NBIN-1) : $urandom_range(10, 13));
      run(n, q, $urandom_range(10, 13));
    end

    // asynchronous reset while a result is being presented
    clr_mon();
    cfg_len = 3; go = 1; step(); go = 0;
    n = 0;
    while (!out_vld && n < 500) begin
      in_vld = 1; in_data = 8'd42; out_rdy = 0; step(); n++;
    end
    in_vld = 0;
    chk("reached_present", out_vld, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_outputs", {in_rdy, stat_start, stat_finish, stat_data, stat_vld, stat_index,
        stat_get_summary, out_bin, out_cnt, out_vld, busy, done}, 64'd0);
    step(); step();
    rst_n = 1;
    clr_mon();
    step(); step();
    chk("post_reset_pulses", n_start + n_fin + n_done + n_vld, 0);
    chk("post_reset_busy", busy, 0);

    q.delete();
    n = $urandom_range(1, 20);
    for (int i = 0; i < n; i++) q.push_back($urandom_range(0, NBIN-1));
    run(n, q, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
